// File: rtl/dma_frame_sequencer_pkg.sv
// dma_frame_sequencer_pkg: shared FSM states, interrupt bit indices and default widths
package dma_frame_sequencer_pkg;
  localparam int DEF_ADDR_FIFO_DEPTH = 4;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_LINE_GAP_WIDTH = 32;
  localparam int DEF_LINES_WIDTH = 12;
  localparam int DEF_LEN_WIDTH = 16;
  localparam int INT_FRAME_DONE = 0;
  localparam int INT_UNDERRUN = 1;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_DONE} seq_state_e;
endpackage

// File: rtl/dma_frame_sequencer_addr_fifo.sv
// dma_addr_fifo: synchronous base-address FIFO; a push while full is accepted only alongside a pop
module dma_addr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata = mem[rd_ptr];
  always_ff @(posedge aclk)
    if (do_push) mem[wr_ptr] <= wdata;
  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/dma_frame_sequencer.sv
// dma_frame_sequencer: queues frame base addresses and issues one DMA write command per line.
// Optional DMA_SEQ_BUF_RECYCLE_EN: start on an empty queue reuses the last popped base.
module dma_frame_sequencer
  import dma_frame_sequencer_pkg::*;
#(
  parameter int ADDR_FIFO_DEPTH = DEF_ADDR_FIFO_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINE_GAP_WIDTH = DEF_LINE_GAP_WIDTH,
  parameter int LINES_WIDTH = DEF_LINES_WIDTH,
  parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [ADDR_WIDTH-1:0]            buff_addr_fifo_data,
  input  logic                             buff_addr_fifo_wen,
  input  logic                             ctrl_start,
  input  logic                             ctrl_stop,
  input  logic [LINE_GAP_WIDTH-1:0]        line_gap,
  input  logic [LINES_WIDTH-1:0]           num_lines,
  input  logic [LEN_WIDTH-1:0]             line_bytes,
  input  logic                             glbl_int_en,
  input  logic [1:0]                       interrupt_en,
  input  logic [1:0]                       interrupt_status_clr,
  output logic                             cmd_valid,
  input  logic                             cmd_ready,
  output logic [ADDR_WIDTH-1:0]            cmd_addr,
  output logic [LEN_WIDTH-1:0]             cmd_len,
  input  logic                             line_done,
  output logic                             busy,
  output logic                             fifo_full,
  output logic [$clog2(ADDR_FIFO_DEPTH):0] fifo_level,
  output logic [1:0]                       interrupt_status,
  output logic                             irq
);
  seq_state_e state, state_nxt;
  logic [ADDR_WIDTH-1:0] fifo_head, start_base, acc;
  logic [LINES_WIDTH-1:0] line_cnt, lines_tgt, lines_eff;
  logic fifo_empty, idle_start, go, last_line;
  logic [1:0] set_bits;
  dma_addr_fifo #(.DEPTH(ADDR_FIFO_DEPTH), .WIDTH(ADDR_WIDTH)) u_fifo (
    .aclk(aclk), .areset(areset), .push(buff_addr_fifo_wen), .wdata(buff_addr_fifo_data),
    .pop(idle_start), .rdata(fifo_head), .full(fifo_full), .empty(fifo_empty), .level(fifo_level)
  );
  assign idle_start = state == S_IDLE && ctrl_start;
`ifdef DMA_SEQ_BUF_RECYCLE_EN
  logic [ADDR_WIDTH-1:0] last_base;
  assign go = idle_start;
  assign start_base = fifo_empty ? last_base : fifo_head;
  always_ff @(posedge aclk)
    last_base <= areset ? '0 : go ? start_base : last_base;
`else
  assign go = idle_start && !fifo_empty;
  assign start_base = fifo_head;
`endif
  assign busy = state != S_IDLE;
  assign lines_eff = lines_tgt == '0 ? LINES_WIDTH'(1) : lines_tgt;
  assign last_line = line_cnt + LINES_WIDTH'(1) == lines_eff;
  always_comb begin
    set_bits = '0;
    set_bits[INT_UNDERRUN] = idle_start && fifo_empty;
    set_bits[INT_FRAME_DONE] = state == S_DONE;
  end
  always_ff @(posedge aclk)
    state <= areset ? S_IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = go ? S_LOAD : S_IDLE;
      S_LOAD:  state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = cmd_ready ? S_WAIT : S_ISSUE;
      S_WAIT:  state_nxt = !line_done ? S_WAIT : last_line ? S_DONE : ctrl_stop ? S_IDLE : S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end
  // line address is a running sum of line_gap, sampled once per line in LOAD
  always_ff @(posedge aclk) begin
    if (areset) begin
      cmd_valid <= 1'b0;
      cmd_addr <= '0;
      cmd_len <= '0;
      acc <= '0;
      line_cnt <= '0;
      lines_tgt <= '0;
      interrupt_status <= '0;
      irq <= 1'b0;
    end else begin
      if (go) begin
        acc <= start_base;
        line_cnt <= '0;
      end
      if (state == S_LOAD) begin
        cmd_addr <= acc;
        acc <= acc + ADDR_WIDTH'(line_gap);
        cmd_len <= line_bytes;
        lines_tgt <= num_lines;
        cmd_valid <= 1'b1;
      end
      if (state == S_ISSUE && cmd_ready) cmd_valid <= 1'b0;
      if (state == S_WAIT && line_done) line_cnt <= line_cnt + 1'b1;
      interrupt_status <= (interrupt_status & ~interrupt_status_clr) | set_bits;
      irq <= glbl_int_en & |(interrupt_status & interrupt_en);
    end
  end
endmodule

// File: tb/tb_dma_frame_sequencer.sv
// tb_dma_frame_sequencer: directed plus randomized frames checked against a queue/arithmetic model
module tb_dma_frame_sequencer;
  logic aclk = 0, areset = 1;
  logic [31:0] buff_addr_fifo_data = 0;
  logic buff_addr_fifo_wen = 0, ctrl_start = 0, ctrl_stop = 0;
  logic [31:0] line_gap = 0;
  logic [11:0] num_lines = 0;
  logic [15:0] line_bytes = 0;
  logic glbl_int_en = 0;
  logic [1:0] interrupt_en = 0, interrupt_status_clr = 0;
  logic cmd_valid, cmd_ready = 0, line_done = 0;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic busy, fifo_full, irq;
  logic [2:0] fifo_level;
  logic [1:0] interrupt_status;
  int total = 0, bad = 0;
  logic [31:0] q[$];
  logic [31:0] last_base = 0;

  dma_frame_sequencer dut (
    .aclk(aclk), .areset(areset), .buff_addr_fifo_data(buff_addr_fifo_data),
    .buff_addr_fifo_wen(buff_addr_fifo_wen), .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop),
    .line_gap(line_gap), .num_lines(num_lines), .line_bytes(line_bytes),
    .glbl_int_en(glbl_int_en), .interrupt_en(interrupt_en),
    .interrupt_status_clr(interrupt_status_clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .line_done(line_done), .busy(busy),
    .fifo_full(fifo_full), .fifo_level(fifo_level), .interrupt_status(interrupt_status), .irq(irq)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    buff_addr_fifo_data = d;
    buff_addr_fifo_wen = 1;
    tick;
    buff_addr_fifo_wen = 0;
    if (q.size() < 4) q.push_back(d);
  endtask

  task automatic clr_status;
    interrupt_status_clr = 2'b11;
    tick;
    interrupt_status_clr = 0;
  endtask

  // start a frame and walk every line; expected line address = base + n*gap (mod 2^32)
  task automatic frame(input logic push_en, input logic [31:0] pdata, input int stop_at, input int stall);
    logic [31:0] base, exp_a;
    logic [15:0] exp_len;
    int n_eff;
    base = q.size() > 0 ? q.pop_front() : last_base;
    last_base = base;
    if (push_en) q.push_back(pdata);
    n_eff = num_lines == 0 ? 1 : int'(num_lines);
    exp_len = line_bytes;
    ctrl_start = 1;
    buff_addr_fifo_wen = push_en;
    buff_addr_fifo_data = pdata;
    tick;
    ctrl_start = 0;
    buff_addr_fifo_wen = 0;
    chk("busy_after_start", busy, 1);
    for (int n = 0; n < n_eff; n++) begin
      chk("valid_in_load", cmd_valid, 0);
      tick;
      exp_a = base + 32'(n) * line_gap;
      chk("cmd_valid", cmd_valid, 1);
      chk("cmd_addr", cmd_addr, exp_a);
      chk("cmd_len", cmd_len, exp_len);
      for (int s = 0; s < stall; s++) begin
        line_done = s == 0;
        tick;
        line_done = 0;
        chk("hold_valid", cmd_valid, 1);
        chk("hold_addr", cmd_addr, exp_a);
        chk("hold_len", cmd_len, exp_len);
      end
      cmd_ready = 1;
      tick;
      cmd_ready = 0;
      chk("valid_drop", cmd_valid, 0);
      repeat ($urandom_range(0, 2)) tick;
      chk("no_second_cmd", cmd_valid, 0);
      ctrl_stop = n == stop_at;
      line_done = 1;
      tick;
      line_done = 0;
      ctrl_stop = 0;
      if (n == stop_at && n < n_eff - 1) begin
        chk("stop_idle", busy, 0);
        chk("stop_no_done", interrupt_status[0], 0);
        tick;
        chk("stop_no_cmd", cmd_valid, 0);
        return;
      end
    end
    chk("busy_in_done", busy, 1);
    tick;
    chk("frame_done", interrupt_status[0], 1);
    chk("idle_after_frame", busy, 0);
  endtask

  initial begin
    logic [31:0] b;
    repeat (3) tick;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_status", interrupt_status, 0);
    chk("rst_irq", irq, 0);
    chk("rst_addr", cmd_addr, 0);
    areset = 0;
    tick;

    // directed frame with interrupt
    glbl_int_en = 1;
    interrupt_en = 2'b01;
    line_gap = 32'h2000;
    num_lines = 3;
    line_bytes = 16'h780;
    push(32'h1000_0000);
    chk("level_one", fifo_level, 1);
    frame(0, 0, -1, 0);
    chk("irq_not_yet", irq, 0);
    tick;
    chk("irq_set", irq, 1);
    interrupt_status_clr = 2'b01;
    tick;
    interrupt_status_clr = 0;
    chk("status_cleared", interrupt_status, 0);
    tick;
    chk("irq_cleared", irq, 0);

    // backpressure
    num_lines = 1;
    push(32'h2000_0040);
    frame(0, 0, -1, 5);
    clr_status;

    // queue overflow, then a push that coincides with a pop while full
    for (int i = 0; i < 5; i++) push(32'h3000_0000 + 32'(i) * 32'h100);
    chk("q_full", fifo_full, 1);
    chk("q_level4", fifo_level, 4);
    frame(1, 32'h3000_0F00, -1, 0);
    chk("q_level_after_swap", fifo_level, 4);
    clr_status;
    for (int i = 0; i < 4; i++) begin
      frame(0, 0, -1, 0);
      clr_status;
      chk("q_level_drain", fifo_level, q.size());
    end
    chk("q_empty", fifo_level, 0);

    // underrun
    interrupt_en = 2'b10;
`ifdef DMA_SEQ_BUF_RECYCLE_EN
    frame(0, 0, -1, 0);
    chk("underrun_status", interrupt_status[1], 1);
`else
    ctrl_start = 1;
    tick;
    ctrl_start = 0;
    chk("underrun_status", interrupt_status, 2'b10);
    chk("underrun_busy", busy, 0);
`endif
    tick;
    chk("underrun_irq", irq, 1);
    clr_status;
    interrupt_en = 2'b01;

    // stop during line 1 of a 4-line frame
    num_lines = 4;
    push(32'h4000_0000);
    frame(0, 0, 1, 0);
    clr_status;

    // address wrap
    num_lines = 2;
    line_gap = 32'h2000;
    push(32'hFFFF_F000);
    frame(0, 0, -1, 0);
    clr_status;

    // randomized frames
    for (int r = 0; r < 8; r++) begin
      b = $urandom;
      line_gap = $urandom;
      num_lines = 12'($urandom_range(0, 4));
      line_bytes = 16'($urandom);
      push(b);
      frame(0, 0, -1, $urandom_range(0, 3));
      clr_status;
    end

    // reset mid-WAIT, with an ignored start while busy
    num_lines = 3;
    push(32'h5000_0000);
    push(32'h6000_0000);
    ctrl_start = 1;
    tick;
    ctrl_start = 0;
    tick;
    chk("pre_rst_valid", cmd_valid, 1);
    cmd_ready = 1;
    tick;
    cmd_ready = 0;
    ctrl_start = 1;
    tick;
    ctrl_start = 0;
    chk("start_ignored_level", fifo_level, 1);
    chk("start_ignored_status", interrupt_status, 0);
    chk("start_ignored_busy", busy, 1);
    areset = 1;
    tick;
    areset = 0;
    chk("midrst_valid", cmd_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_status", interrupt_status, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dma_frame_sequencer.md
Name: dma_frame_sequencer

Overview:
Frame-level scheduler for the write DMA. It queues frame-buffer base addresses written by the register block, and on a start command issues one write-burst command per video line to the DMA engine. Line addresses are computed as base + n*line_gap. It raises frame-done and underrun interrupts through the existing enable/status/clear register scheme. It sits between write_reg_dma-style register outputs and the AXI write DMA engine.

Parameters:
ADDR_FIFO_DEPTH, 4, number of queued buffer base addresses (power of 2, at least 2)
ADDR_WIDTH, 32, byte address width
LINE_GAP_WIDTH, 32, width of the line stride
LINES_WIDTH, 12, width of the line-count field
LEN_WIDTH, 16, width of the per-line byte count

Ports:
aclk  in  1  clock
areset  in  1  synchronous reset, active-high
buff_addr_fifo_data  in  ADDR_WIDTH  base address to enqueue
buff_addr_fifo_wen  in  1  one-cycle push strobe
ctrl_start  in  1  one-cycle pulse; start a frame
ctrl_stop  in  1  level; finish current line, then idle
line_gap  in  LINE_GAP_WIDTH  byte stride between line starts
num_lines  in  LINES_WIDTH  lines per frame (0 treated as 1)
line_bytes  in  LEN_WIDTH  bytes per line command
glbl_int_en  in  1  global interrupt enable
interrupt_en  in  2  bit0 frame_done, bit1 underrun
interrupt_status_clr  in  2  one-cycle write-1-to-clear
cmd_valid  out  1  line command valid
cmd_ready  in  1  DMA accepts command
cmd_addr  out  ADDR_WIDTH  line start address
cmd_len  out  LEN_WIDTH  line byte count
line_done  in  1  one-cycle pulse; DMA completed a line
busy  out  1  frame in progress
fifo_full  out  1  address queue full
fifo_level  out  clog2(DEPTH)+1  queued entries
interrupt_status  out  2  sticky status
irq  out  1  interrupt request

Behaviour:
- All state updates on posedge aclk. areset=1 forces: queue empty, FSM IDLE, cmd_valid=0, cmd_addr=0, cmd_len=0, busy=0, interrupt_status=0, irq=0.
- Queue: push on buff_addr_fifo_wen when not full. A push while full is dropped and the level is unchanged. A push in the same cycle as a pop while full is accepted.
- FSM states: IDLE, LOAD, ISSUE, WAIT, DONE.
- IDLE: on ctrl_start with queue non-empty, pop the head into base, set line_cnt=0, go to LOAD. On ctrl_start with queue empty, set status bit1 (underrun) and stay in IDLE.
- LOAD: cmd_addr=base+line_cnt*line_gap, computed as a running accumulator (add line_gap per line, no multiplier). Truncate modulo 2^ADDR_WIDTH. Set cmd_len=line_bytes, assert cmd_valid, go to ISSUE.
- ISSUE: hold cmd_valid, cmd_addr and cmd_len stable until cmd_ready. On the handshake, drop cmd_valid next cycle and go to WAIT.
- WAIT: on line_done, increment line_cnt. If line_cnt+1 equals max(num_lines,1), go to DONE. Otherwise, if ctrl_stop is high, go to IDLE. Otherwise go to LOAD.
- DONE: set status bit0 for one cycle, then go to IDLE.
- Latency: ctrl_start to cmd_valid is 2 cycles; line_done to the next cmd_valid is 2 cycles.
- busy=1 in every state except IDLE.
- line_gap, num_lines and line_bytes are sampled in LOAD, so changes take effect at the next line.
- A ctrl_start while not IDLE is ignored.
- line_done outside WAIT is ignored.
- Status bits are sticky. If set and clear hit in the same cycle, set wins.
- irq is registered: irq = glbl_int_en & |(interrupt_status & interrupt_en). It asserts 1 cycle after the status bit sets.

Optional Feature:
Macro DMA_SEQ_BUF_RECYCLE_EN.
- Defined: ctrl_start with an empty queue reuses the last popped base address and starts the frame; underrun status still sets. After reset, the last base is 0.
- Undefined: behaviour exactly as above (stay in IDLE, underrun set).

Decomposition:
- Shared package/include holds: FSM state encodings, interrupt bit indices (INT_FRAME_DONE=0, INT_UNDERRUN=1), default widths.
- One sub-module, dma_addr_fifo: synchronous FIFO with full/empty/level.

Test Plan:
- Reset: assert areset mid-WAIT -> next cycle cmd_valid=0, busy=0, fifo_level=0, interrupt_status=0.
- Frame run:
  - Stimulus: push 0x1000_0000; line_gap=0x2000, num_lines=3, line_bytes=0x780; ctrl_start; cmd_ready=1; line_done pulses.
  - Response: cmd_addr sequence 0x1000_0000, 0x1000_2000, 0x1000_4000; status bit0 set.
  - With glbl_int_en=1 and interrupt_en=1, irq=1 one cycle later. Clear 0x1 -> irq=0.
- Backpressure: cmd_ready low for 5 cycles -> cmd_valid, cmd_addr and cmd_len held constant; exactly one command accepted.
- Queue: push 5 entries with depth 4 -> fifo_full=1, level=4, 5th entry dropped. Four frames then use the first four addresses in order.
- Underrun: ctrl_start with an empty queue -> status=0x2, busy stays 0. With DMA_SEQ_BUF_RECYCLE_EN defined, the frame restarts at the previous base.
- Stop and wrap:
  - ctrl_stop high during line 1 of a 4-line frame -> IDLE after that line_done; no frame_done.
  - Base 0xFFFF_F000 with gap 0x2000 -> second cmd_addr = 0x0000_1000.
